// File: rtl/prism_sp_unit_puzzle_fifo_w_gather_if.sv
// fifo_write_interface: write side of a FIFO.
//   wr_en   - write strobe, driven by the master
//   wr_data - write data (DATA_WIDTH bits), driven by the master
//   full    - FIFO cannot take a word this cycle, driven by the slave
interface fifo_write_interface #(
    parameter int unsigned DATA_WIDTH = 128
) ();
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  full;

    modport master (output wr_en, output wr_data, input full);
    modport slave  (input wr_en, input wr_data, output full);
endinterface

// File: rtl/prism_sp_unit_puzzle_fifo_w_gather.sv
// prism_sp_unit_puzzle_fifo_w_gather
// Packs 1..IN_LANES chunks of IN_WIDTH bits per accepted beat, little-end
// first, into DATA_WIDTH-bit words and pushes them out through a one-word
// holding stage that honours fifo_w.full.
//
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   pulse         - beat strobe, accepted when ready=1
//   in            - chunks, lane k at [k*IN_WIDTH +: IN_WIDTH], lane 0 first
//   in_cnt        - valid lanes this beat (clamped to IN_LANES)
//   flush         - emit the partial assembly word, zero padded
//   fifo_w        - FIFO write master (wr_en, wr_data out; full in)
//   ready         - !pend_valid | !fifo_w.full
//   fill          - slots occupied in the assembly word
//   words_written - count of wr_en cycles, wraps
//   overflow      - sticky: request while not ready, or illegal flush
//
// DATA_WIDTH must equal the DATA_WIDTH of the connected fifo_w instance.
module prism_sp_unit_puzzle_fifo_w_gather #(
    parameter int unsigned IN_WIDTH   = 32,
    parameter int unsigned IN_LANES   = 4,
    parameter int unsigned CNT_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH = 128,
    localparam int unsigned NSLOTS    = (DATA_WIDTH + IN_WIDTH - 1) / IN_WIDTH,
    localparam int unsigned FILL_W    = (NSLOTS > 1) ? $clog2(NSLOTS) : 1,
    localparam int unsigned ICNT_W    = $clog2(IN_LANES + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pulse,
    input  logic [IN_LANES*IN_WIDTH-1:0] in,
    input  logic [ICNT_W-1:0]            in_cnt,
    input  logic                         flush,
    fifo_write_interface.master          fifo_w,
    output logic                         ready,
    output logic [FILL_W-1:0]            fill,
    output logic [CNT_WIDTH-1:0]         words_written,
    output logic                         overflow
);

    // Assembly is done in a slot-aligned buffer NSLOTS*IN_WIDTH wide; bits
    // above DATA_WIDTH are the discarded upper part of a narrow last slot.
    localparam int unsigned WIDE_W = NSLOTS * IN_WIDTH;

    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [FILL_W-1:0]     fill_q, fill_d;
    logic [DATA_WIDTH-1:0] pend_data_q, pend_data_d;
    logic                  pend_valid_q, pend_valid_d;
    logic                  overflow_q, overflow_d;
    logic [CNT_WIDTH-1:0]  words_q, words_d;

    logic                  wr_en_c;
    logic                  ready_c;
    logic                  beat_go;
    logic                  flush_go;
    logic                  complete;
    logic                  illegal;
    logic                  load;
    int unsigned           n;
    int unsigned           fill_u;
    int unsigned           total;
    int unsigned           r;
    logic [WIDE_W-1:0]     wide_ins;
    logic [WIDE_W-1:0]     wide_res;
    logic [DATA_WIDTH-1:0] new_word;

    always_comb begin
        n = 32'(in_cnt);
        if (n > IN_LANES) n = IN_LANES;
        fill_u   = 32'(fill_q);

        wr_en_c  = pend_valid_q & ~fifo_w.full;
        ready_c  = ~pend_valid_q | ~fifo_w.full;
        beat_go  = pulse & ready_c & (n != 0);
        flush_go = flush & ready_c;

        total    = fill_u + n;
        complete = beat_go && (total >= NSLOTS);
        r        = complete ? (total - NSLOTS) : 0;
        illegal  = flush_go && complete && (r != 0);

        // Chunks landing in the current word: lane k goes to slot fill+k.
        wide_ins = '0;
        wide_ins[DATA_WIDTH-1:0] = acc_q;
        for (int unsigned s = 0; s < NSLOTS; s++) begin
            for (int unsigned k = 0; k < IN_LANES; k++) begin
                if (beat_go && (k < n) && (fill_u + k == s))
                    wide_ins[s*IN_WIDTH +: IN_WIDTH] = in[k*IN_WIDTH +: IN_WIDTH];
            end
        end

        // Residue spilling into a fresh word: lane k goes to slot fill+k-NSLOTS.
        wide_res = '0;
        for (int unsigned s = 0; s < IN_LANES; s++) begin
            for (int unsigned k = 0; k < IN_LANES; k++) begin
                if (beat_go && (k < n) && (fill_u + k == s + NSLOTS))
                    wide_res[s*IN_WIDTH +: IN_WIDTH] = in[k*IN_WIDTH +: IN_WIDTH];
            end
        end

        acc_d        = acc_q;
        fill_d       = fill_q;
        pend_data_d  = pend_data_q;
        pend_valid_d = pend_valid_q & ~wr_en_c;
        load         = 1'b0;
        new_word     = acc_q;

        if (beat_go) begin
            if (complete) begin
                load     = 1'b1;
                new_word = wide_ins[DATA_WIDTH-1:0];
                acc_d    = wide_res[DATA_WIDTH-1:0];
                fill_d   = FILL_W'(r);
            end else begin
                acc_d    = wide_ins[DATA_WIDTH-1:0];
                fill_d   = FILL_W'(total);
            end
        end

        // Flush acts on the post-beat state. When the beat already completed
        // a word, flush either has nothing left (r=0) or is illegal (r>0).
        if (flush_go && !complete && (fill_d != '0)) begin
            load     = 1'b1;
            new_word = acc_d;
            acc_d    = '0;
            fill_d   = '0;
        end

        // A load can only happen when ready, so it never overwrites an
        // undrained word; it keeps pend_valid set across a same-edge drain.
        if (load) begin
            pend_data_d  = new_word;
            pend_valid_d = 1'b1;
        end

        overflow_d = overflow_q | ((pulse | flush) & ~ready_c) | illegal;
        words_d    = words_q + CNT_WIDTH'(wr_en_c);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q        <= '0;
            fill_q       <= '0;
            pend_data_q  <= '0;
            pend_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            words_q      <= '0;
        end else begin
            acc_q        <= acc_d;
            fill_q       <= fill_d;
            pend_data_q  <= pend_data_d;
            pend_valid_q <= pend_valid_d;
            overflow_q   <= overflow_d;
            words_q      <= words_d;
        end
    end

    assign fifo_w.wr_en   = wr_en_c;
    assign fifo_w.wr_data = pend_data_q;
    assign ready          = ready_c;
    assign fill           = fill_q;
    assign words_written  = words_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_prism_sp_unit_puzzle_fifo_w_gather.sv
module tb_prism_sp_unit_puzzle_fifo_w_gather;

    localparam int unsigned DW = 128;
    localparam int unsigned IW = 32;
    localparam int unsigned IL = 4;
    localparam int unsigned CW = 32;
    localparam int unsigned NS = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic               pulse, flush;
    logic [IL*IW-1:0]   din;
    logic [2:0]         in_cnt;
    logic               ready, overflow;
    logic [1:0]         fill;
    logic [CW-1:0]      words_written;

    fifo_write_interface #(.DATA_WIDTH(DW)) fw ();

    prism_sp_unit_puzzle_fifo_w_gather #(
        .IN_WIDTH(IW), .IN_LANES(IL), .CNT_WIDTH(CW), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .rst(rst), .pulse(pulse), .in(din), .in_cnt(in_cnt),
        .flush(flush), .fifo_w(fw.master), .ready(ready), .fill(fill),
        .words_written(words_written), .overflow(overflow)
    );

    // Narrow-last-slot instance: 48-bit words from 32-bit chunks.
    logic        pulse2, flush2, ready2, overflow2;
    logic [31:0] din2;
    logic [0:0]  in_cnt2, fill2;
    logic [CW-1:0] words2;

    fifo_write_interface #(.DATA_WIDTH(48)) fw2 ();

    prism_sp_unit_puzzle_fifo_w_gather #(
        .IN_WIDTH(32), .IN_LANES(1), .CNT_WIDTH(CW), .DATA_WIDTH(48)
    ) dut48 (
        .clk(clk), .rst(rst), .pulse(pulse2), .in(din2), .in_cnt(in_cnt2),
        .flush(flush2), .fifo_w(fw2.master), .ready(ready2), .fill(fill2),
        .words_written(words2), .overflow(overflow2)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: the stream of chunks not yet emitted, whether a word
    // is waiting to drain, the sticky overflow and the write count.
    logic [IW-1:0] mq[$];
    logic [DW-1:0] exp_q[$];
    bit            p_m;
    bit            ovf_m;
    logic [CW-1:0] wcnt_m;
    logic [DW-1:0] last_word;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic emit(input int unsigned m);
        logic [DW-1:0] w;
        w = '0;
        for (int unsigned s = 0; s < m; s++) w[s*IW +: IW] = mq.pop_front();
        exp_q.push_back(w);
    endtask

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        p_m = 0;
        ovf_m = 0;
        wcnt_m = '0;
    endtask

    // Advance the model by one clock edge given this cycle's inputs.
    task automatic model_step(input bit pl, input logic [IL*IW-1:0] d, input int unsigned cnt,
                              input bit fl, input bit fu);
        bit rdy, wr, loaded, completes, bad;
        int unsigned n, f0;
        rdy = !p_m || !fu;
        wr = p_m && !fu;
        loaded = 0;
        if ((pl || fl) && !rdy) begin
            ovf_m = 1;
        end else if (pl || fl) begin
            n = pl ? ((cnt > IL) ? IL : cnt) : 0;
            f0 = mq.size();
            completes = (n > 0) && (f0 + n >= NS);
            bad = fl && completes && (f0 + n > NS);
            for (int unsigned k = 0; k < n; k++) mq.push_back(d[k*IW +: IW]);
            if (mq.size() >= NS) begin
                emit(NS);
                loaded = 1;
            end
            if (bad) ovf_m = 1;
            else if (fl && !completes && mq.size() > 0) begin
                emit(mq.size());
                loaded = 1;
            end
        end
        if (wr) wcnt_m = wcnt_m + 1'b1;
        p_m = loaded || (p_m && !wr);
    endtask

    // One clock cycle: drive inputs after the edge, check observable state,
    // then step the model for the coming edge.
    task automatic cyc(input bit pl, input logic [IL*IW-1:0] d, input int unsigned cnt,
                       input bit fl, input bit fu);
        @(posedge clk);
        #2;
        pulse = pl;
        din = d;
        in_cnt = cnt[2:0];
        flush = fl;
        fw.full = fu;
        #2;
        check("ready", DW'(ready), DW'(!p_m || !fu));
        check("wr_en", DW'(fw.wr_en), DW'(p_m && !fu));
        check("fill", DW'(fill), DW'(mq.size()));
        check("overflow", DW'(overflow), DW'(ovf_m));
        check("words_written", DW'(words_written), DW'(wcnt_m));
        model_step(pl, d, cnt, fl, fu);
    endtask

    function automatic logic [IL*IW-1:0] rnd_in();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: every written word must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && fw.wr_en) begin
            if (exp_q.size() == 0) check("spurious_wr_en", DW'(fw.wr_en), '0);
            else check("wr_data", fw.wr_data, exp_q.pop_front());
            last_word = fw.wr_data;
        end
    end

    initial begin
        rst = 1'b1;
        pulse = 0; flush = 0; din = '0; in_cnt = '0; fw.full = 1'b0;
        pulse2 = 0; flush2 = 0; din2 = '0; in_cnt2 = '0; fw2.full = 1'b0;
        last_word = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Four single-chunk beats make one word.
        cyc(1, 128'h11, 1, 0, 0);
        cyc(1, 128'h22, 1, 0, 0);
        cyc(1, 128'h33, 1, 0, 0);
        cyc(1, 128'h44, 1, 0, 0);
        cyc(0, '0, 0, 0, 0);
        cyc(0, '0, 0, 0, 0);
        check("word_11_44", last_word, 128'h00000044_00000033_00000022_00000011);

        // Three + three lanes: one word plus residue, then flush the residue.
        cyc(1, {32'h0, 32'hC0C0C0C0, 32'hB0B0B0B0, 32'hA0A0A0A0}, 3, 0, 0);
        cyc(1, {32'h0, 32'hF0F0F0F0, 32'hE0E0E0E0, 32'hD0D0D0D0}, 3, 0, 0);
        cyc(0, '0, 0, 0, 0);
        cyc(0, '0, 0, 0, 0);
        check("word_dcba", last_word, 128'hD0D0D0D0_C0C0C0C0_B0B0B0B0_A0A0A0A0);
        check("fill_after_residue", DW'(fill), DW'(2));
        cyc(0, '0, 0, 1, 0);
        cyc(0, '0, 0, 0, 0);
        cyc(0, '0, 0, 0, 0);
        check("word_flush_fe", last_word, 128'h0_0_F0F0F0F0_E0E0E0E0);

        // Sustained full-width beats: one word per cycle.
        for (int i = 0; i < 8; i++) cyc(1, rnd_in(), 4, 0, 0);
        cyc(0, '0, 0, 0, 0);
        cyc(0, '0, 0, 0, 0);

        // 48-bit instance: last slot keeps only 16 bits of the chunk.
        @(posedge clk); #2 pulse2 = 1; din2 = 32'hAAAA5555; in_cnt2 = 1'b1;
        @(posedge clk); #2 din2 = 32'h1234BEEF;
        @(posedge clk); #2 pulse2 = 0;
        #2;
        check("w48_wr_en", DW'(fw2.wr_en), DW'(1));
        check("w48_wr_data", DW'(fw2.wr_data), DW'(48'hBEEF_AAAA5555));

        // Randomized traffic including clamped counts, flushes and backpressure.
        for (int i = 0; i < 3000; i++)
            cyc(($urandom % 4) != 0, rnd_in(), $urandom_range(0, 7),
                ($urandom % 6) == 0, ($urandom % 3) == 0);
        for (int i = 0; i < 3; i++) cyc(0, '0, 0, 0, 0);
        check("scoreboard_drained", DW'(exp_q.size()), '0);

        // Fresh state, then hold a word under full and poke it.
        @(posedge clk); #2 rst = 1'b1; model_reset();
        @(posedge clk); #2 rst = 1'b0;
        cyc(1, rnd_in(), 4, 0, 1);
        cyc(1, rnd_in(), 2, 0, 1);
        cyc(0, '0, 0, 0, 1);
        check("overflow_on_full", DW'(overflow), DW'(1));
        check("fill_unchanged", DW'(fill), DW'(0));
        cyc(0, '0, 0, 0, 0);
        cyc(0, '0, 0, 0, 0);
        check("ready_after_drain", DW'(ready), DW'(1));

        // Asynchronous reset with fill=2 and a word pending.
        cyc(1, rnd_in(), 2, 0, 0);
        cyc(1, rnd_in(), 4, 0, 1);
        cyc(0, '0, 0, 0, 1);
        #3 rst = 1'b1;
        #1;
        model_reset();
        check("rst_fill", DW'(fill), '0);
        check("rst_ready", DW'(ready), DW'(1));
        check("rst_wr_en", DW'(fw.wr_en), '0);
        check("rst_overflow", DW'(overflow), '0);
        check("rst_words", DW'(words_written), '0);
        @(posedge clk); #2 rst = 1'b0;
        for (int i = 0; i < 4; i++) cyc(0, '0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
